// File: rtl/uart_pkg.sv
// Types shared by the UART transmit/receive users and the tx feeder.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    FEED_IDLE      = 2'd0,
    FEED_ARM       = 2'd1,
    FEED_STROBE    = 2'd2,
    FEED_WAIT_DONE = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; read data is registered and updates one cycle after a pop.
// Push is ignored while full and pop while empty; count never wraps.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = rdata_q;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two gives the wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      rdata_d  = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send sequencer for an edge-triggered UART transmitter: a byte pushed into an
// idle, empty feeder is on tx_data one cycle later and tx_send rises the cycle after; in_ready = !full.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  uart_byte_t             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output uart_byte_t             tx_data,
  output logic                   tx_send,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  feeder_state_t state_q;
  logic          send_q;
  logic          pop;
  logic          fifo_empty, fifo_full;
  uart_byte_t    fifo_rdata;

  assign pop      = (state_q == FEED_IDLE) && !fifo_empty && tx_ready;
  assign in_ready = !fifo_full;
  assign empty    = fifo_empty;
  assign full     = fifo_full;
  assign tx_data  = fifo_rdata;
  assign tx_send  = send_q;

  sync_fifo #(
    .WIDTH($bits(uart_byte_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (in_valid),
    .pop  (pop),
    .wdata(in_data),
    .rdata(fifo_rdata),
    .count(count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // send drops only once the transmitter has shown it latched the byte (ready low).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FEED_IDLE;
      send_q  <= 1'b0;
    end else begin
      case (state_q)
        FEED_IDLE: begin
          send_q <= 1'b0;
          if (pop) state_q <= FEED_ARM;
        end
        FEED_ARM: begin
          state_q <= FEED_STROBE;
          send_q  <= 1'b1;
        end
        FEED_STROBE: begin
          if (!tx_ready) begin
            state_q <= FEED_WAIT_DONE;
            send_q  <= 1'b0;
          end
        end
        FEED_WAIT_DONE: begin
          if (tx_ready) state_q <= FEED_IDLE;
        end
        default: begin
          state_q <= FEED_IDLE;
          send_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: behavioural 4-clocks-per-bit transmitter, serial frame decoder,
// handshake protocol monitor, and queue-based expected byte order.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_ready;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx_data (tx_data),
    .tx_send (tx_send),
    .tx_ready(tx_ready),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Transmitter stand-in: latches on a rising send, optionally keeps ready high for hold_cfg
  // cycles, then sends start + 8 data bits LSB-first + stop at 4 clocks per bit.
  bit         manual    = 1'b0;
  bit         man_ready = 1'b0;
  int         hold_cfg  = 0;
  logic       xm_ready  = 1'b1;
  logic       ser       = 1'b1;
  logic       send_seen = 1'b0;
  int         xm_t      = -1;
  int         xm_wait   = 0;
  logic [7:0] xm_dat    = 8'h00;
  int         latched   = 0;

  assign tx_ready = manual ? man_ready : xm_ready;

  function automatic logic frame_bit(input logic [7:0] d, input int t);
    int b;
    b = t / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    send_seen <= tx_send;
    if (reset) begin
      xm_ready <= 1'b1;
      ser      <= 1'b1;
      xm_t     <= -1;
      xm_wait  <= 0;
    end else if (xm_t < 0) begin
      if (!manual && tx_send === 1'b1 && send_seen === 1'b0) begin
        xm_dat  <= tx_data;
        latched <= latched + 1;
        xm_t    <= 0;
        if (hold_cfg == 0) xm_ready <= 1'b0;
        else xm_wait <= hold_cfg;
      end
    end else if (xm_wait > 0) begin
      xm_wait <= xm_wait - 1;
      if (xm_wait == 1) xm_ready <= 1'b0;
    end else begin
      ser <= frame_bit(xm_dat, xm_t);
      if (xm_t == 39) begin
        xm_t     <= -1;
        xm_ready <= 1'b1;
      end else begin
        xm_t <= xm_t + 1;
      end
    end
  end

  // Serial decoder: samples mid-bit on the falling clock edge.
  logic [7:0] rx_q[$];
  int         frame_err = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (ser === 1'b0) begin : rx_frame
        logic [7:0] b;
        b = 8'h00;
        repeat (2) @(negedge clk);
        if (ser !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = ser;
        end
        repeat (4) @(negedge clk);
        if (ser !== 1'b1) frame_err++;
        rx_q.push_back(b);
      end
    end
  end

  // Handshake monitor: inputs as seen by the DUT at the edge, outputs just after it.
  int         viol_early_drop  = 0;
  int         viol_data_change = 0;
  int         send_rises       = 0;
  logic       pm_send = 1'bx;
  logic [7:0] pm_data = 8'hxx;

  always @(posedge clk) begin : pmon
    logic r_seen, rst_seen;
    r_seen   = tx_ready;
    rst_seen = reset;
    #1;
    if (pm_send === 1'b1 && tx_send === 1'b0 && r_seen === 1'b1 && rst_seen === 1'b0)
      viol_early_drop++;
    if (pm_send === 1'b1 && tx_send === 1'b1 && tx_data !== pm_data)
      viol_data_change++;
    if (pm_send === 1'b0 && tx_send === 1'b1)
      send_rises++;
    pm_send = tx_send;
    pm_data = tx_data;
  end

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    manual = 1'b0; man_ready = 1'b0; hold_cfg = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_send !== 1'b0) $display("FAIL reset_tx_send: got %b want 0", tx_send); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else n_pass++;
    n_checks++; if (count !== 0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    rx_q.delete();
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (count !== 1) $display("FAIL single_count_after_push: got %0d want 1", count); else n_pass++;
    n_checks++; if (tx_send !== 1'b0) $display("FAIL single_send_n0: got %b want 0", tx_send); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx_data !== 8'hA5) $display("FAIL single_tx_data_n1: got %h want a5", tx_data); else n_pass++;
    n_checks++; if (tx_send !== 1'b0) $display("FAIL single_send_n1: got %b want 0", tx_send); else n_pass++;
    n_checks++; if (count !== 0) $display("FAIL single_count_after_pop: got %0d want 0", count); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx_send !== 1'b1) $display("FAIL single_send_n2: got %b want 1", tx_send); else n_pass++;
    wait_rx(1, 200, ok);
    n_checks++;
    if (!ok) $display("FAIL single_frame: got no frame want a5");
    else if (rx_q[0] !== 8'hA5) $display("FAIL single_frame: got %h want a5", rx_q[0]);
    else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_burst();
    logic [7:0] bb [4];
    int peak;
    bit ok;
    bb = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    rx_q.delete();
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = bb[i];
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
    end
    in_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
    end
    n_checks++; if (peak !== 3) $display("FAIL burst_peak_count: got %0d want 3", peak); else n_pass++;
    wait_rx(4, 400, ok);
    n_checks++; if (!ok) $display("FAIL burst_frames: got %0d frames want 4", rx_q.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= rx_q.size()) $display("FAIL burst_byte%0d: got none want %h", i, bb[i]);
      else if (rx_q[i] !== bb[i]) $display("FAIL burst_byte%0d: got %h want %h", i, rx_q[i], bb[i]);
      else n_pass++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_fill();
    bit ok;
    logic [7:0] want;
    rx_q.delete();
    manual = 1'b1; man_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DEPTH + 3; i++) begin
      n_checks++;
      if (in_ready !== (i < DEPTH)) $display("FAIL fill_in_ready%0d: got %b want %b", i, in_ready, (i < DEPTH));
      else n_pass++;
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready_end: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (count !== DEPTH) $display("FAIL fill_count: got %0d want %0d", count, DEPTH); else n_pass++;
    manual = 1'b0;
    wait_rx(DEPTH, 1500, ok);
    repeat (100) @(negedge clk);
    n_checks++; if (rx_q.size() !== DEPTH) $display("FAIL fill_drain_size: got %0d want %0d", rx_q.size(), DEPTH); else n_pass++;
    for (int i = 0; i < DEPTH && i < rx_q.size(); i++) begin
      want = 8'(8'h10 + i);
      n_checks++; if (rx_q[i] !== want) $display("FAIL fill_byte%0d: got %h want %h", i, rx_q[i], want); else n_pass++;
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL fill_empty_after_drain: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] b, d;
    manual = 1'b1; man_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 2; k++) begin
        b = 8'($urandom);
        q.push_back(b);
        in_valid = 1'b1; in_data = b;
        @(negedge clk);
      end
      in_valid = 1'b0;
      for (int it = 0; it < 16; it++) begin
        if (it < 14) begin
          b = 8'($urandom);
          q.push_back(b);
          in_valid = 1'b1; in_data = b;
        end
        man_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; man_ready = 1'b0;
        d = q.pop_front();
        n_checks++; if (tx_data !== d) $display("FAIL wrap_data r%0d i%0d: got %h want %h", r, it, tx_data, d); else n_pass++;
        n_checks++; if (count !== q.size()) $display("FAIL wrap_count r%0d i%0d: got %0d want %0d", r, it, count, q.size()); else n_pass++;
        @(negedge clk);
        n_checks++; if (tx_send !== 1'b1) $display("FAIL wrap_strobe r%0d i%0d: got %b want 1", r, it, tx_send); else n_pass++;
        @(negedge clk);
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        @(negedge clk);
      end
    end
    manual = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c, base_l;
    rx_q.delete();
    manual = 1'b1; man_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h61 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    manual = 1'b0;
    c = 0;
    while (tx_send !== 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    n_checks++; if (tx_send !== 1'b1) $display("FAIL rstmid_reach_strobe: got send %b want 1", tx_send); else n_pass++;
    n_checks++; if (count !== 5) $display("FAIL rstmid_queued: got %0d want 5", count); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (tx_send !== 1'b0) $display("FAIL rstmid_send: got %b want 0", tx_send); else n_pass++;
    n_checks++; if (count !== 0) $display("FAIL rstmid_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL rstmid_empty: got %b want 1", empty); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    base_l = latched;
    in_valid = 1'b1; in_data = 8'h7E;
    @(negedge clk);
    in_valid = 1'b0;
    wait_rx(1, 200, ok);
    repeat (100) @(negedge clk);
    n_checks++; if (rx_q.size() !== 1) $display("FAIL rstmid_frames: got %0d want 1", rx_q.size()); else n_pass++;
    n_checks++;
    if (rx_q.size() < 1) $display("FAIL rstmid_byte: got none want 7e");
    else if (rx_q[0] !== 8'h7E) $display("FAIL rstmid_byte: got %h want 7e", rx_q[0]);
    else n_pass++;
    n_checks++; if (latched - base_l !== 1) $display("FAIL rstmid_latches: got %0d want 1", latched - base_l); else n_pass++;
  endtask

  task automatic test_stub_hold();
    logic [7:0] bb [3];
    bit ok;
    int c, hi, base_l, base_r;
    hold_cfg = 3;
    rx_q.delete();
    base_l = latched;
    base_r = send_rises;
    for (int i = 0; i < 3; i++) begin
      bb[i] = 8'($urandom);
      in_valid = 1'b1; in_data = bb[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    c = 0;
    while (tx_send !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    hi = 0;
    while (tx_send === 1'b1 && hi < 50) begin
      @(negedge clk);
      hi++;
    end
    n_checks++; if (hi !== 5) $display("FAIL hold_send_width: got %0d want 5", hi); else n_pass++;
    wait_rx(3, 400, ok);
    repeat (60) @(negedge clk);
    n_checks++; if (rx_q.size() !== 3) $display("FAIL hold_frames: got %0d want 3", rx_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== bb[i]) $display("FAIL hold_byte%0d: got %h want %h", i, rx_q[i], bb[i]); else n_pass++;
    end
    n_checks++; if (latched - base_l !== 3) $display("FAIL hold_latches: got %0d want 3", latched - base_l); else n_pass++;
    n_checks++; if (send_rises - base_r !== 3) $display("FAIL hold_send_rises: got %0d want 3", send_rises - base_r); else n_pass++;
    hold_cfg = 0;
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] b;
    bit v, ok;
    int flag_bad;
    rx_q.delete();
    hold_cfg = $urandom_range(0, 3);
    flag_bad = 0;
    for (int i = 0; i < 80; i++) begin
      v = ($urandom_range(0, 3) != 0);
      b = 8'($urandom);
      in_valid = v; in_data = b;
      if (v && in_ready === 1'b1) q.push_back(b);
      if (empty !== (count == 0) || full !== (count == DEPTH) || in_ready !== !full || count > DEPTH)
        flag_bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (flag_bad !== 0) $display("FAIL rand_flags: got %0d bad cycles want 0", flag_bad); else n_pass++;
    wait_rx(q.size(), 3000, ok);
    repeat (100) @(negedge clk);
    n_checks++; if (rx_q.size() !== q.size()) $display("FAIL rand_frames: got %0d want %0d", rx_q.size(), q.size()); else n_pass++;
    for (int i = 0; i < q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== q[i]) $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[i], q[i]); else n_pass++;
    end
    hold_cfg = 0;
  endtask

  task automatic test_protocol();
    n_checks++; if (viol_early_drop !== 0) $display("FAIL proto_send_drop_before_ready_low: got %0d want 0", viol_early_drop); else n_pass++;
    n_checks++; if (viol_data_change !== 0) $display("FAIL proto_data_change_while_send: got %0d want 0", viol_data_change); else n_pass++;
    n_checks++; if (frame_err !== 0) $display("FAIL proto_frame_errors: got %0d want 0", frame_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fill();
    test_wrap();
    test_reset_mid();
    test_stub_hold();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
